// File: rtl/pin_sched_pkg.sv
// Shared definitions for the pin command scheduler: register map,
// command type encodings, scheduler states and command word sizing.
package pin_sched_pkg;

  // Register offsets from the block's EBI base word address
  localparam logic [3:0] REG_CTRL     = 4'd0;
  localparam logic [3:0] REG_STATUS   = 4'd1;
  localparam logic [3:0] REG_CMD_PIN  = 4'd2;
  localparam logic [3:0] REG_CMD_TYPE = 4'd3;
  localparam logic [3:0] REG_START_LO = 4'd4;
  localparam logic [3:0] REG_START_HI = 4'd5;
  localparam logic [3:0] REG_DATA_LO  = 4'd6;
  localparam logic [3:0] REG_DATA_HI  = 4'd7;
  localparam logic [3:0] REG_COMMIT   = 4'd8;
  localparam logic [3:0] REG_TIME_LO  = 4'd9;
  localparam logic [3:0] REG_TIME_HI  = 4'd10;
  localparam int         REG_LAST     = 10;

  // CTRL bits
  localparam int CTRL_RUN_BIT   = 0;
  localparam int CTRL_CLR_BIT   = 1;
  localparam int CTRL_FLUSH_BIT = 2;

  // STATUS bits
  localparam int STAT_EMPTY_BIT = 8;
  localparam int STAT_FULL_BIT  = 9;
  localparam int STAT_OVF_BIT   = 10;

  typedef enum logic [1:0] {
    CMD_NOP        = 2'd0,
    CMD_SET_PERIOD = 2'd1,
    CMD_SET_DUTY   = 2'd2,
    CMD_SET_ENABLE = 2'd3
  } cmd_type_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_ISSUE = 2'd2
  } sched_state_e;

  // Command word: pin index, type, 32-bit start time, 32-bit payload
  function automatic int cmd_width(input int pin_w);
    return pin_w + 2 + 64;
  endfunction

endpackage

// File: rtl/pin_cmd_scheduler_cmd_fifo.sv
// Synchronous first-word-fall-through FIFO with flush. Pushes into a full
// FIFO are dropped; flush wins over push and pop in the same cycle.
module cmd_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             pop_data,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push & ~full & ~flush;
  assign do_pop   = pop & ~empty & ~flush;
  assign pop_data = mem[rd_ptr];

  // Storage array, written only on an accepted push
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers and occupancy; flush resets them in one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/pin_cmd_scheduler.sv
// EBI-mapped timestamped command scheduler. Host stages a command in
// registers, commits it into an in-order FIFO, and the scheduler releases
// each command to its pin channel once the global timer reaches its start.
module pin_cmd_scheduler
  import pin_sched_pkg::*;
#(
  parameter int          NUM_PINS   = 8,
  parameter int          FIFO_DEPTH = 16,
  parameter logic [20:0] BASE_ADDR  = 21'h000100,
  parameter int          PIN_W      = $clog2(NUM_PINS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [20:0]         ebi_addr,
  input  logic [15:0]         ebi_data_in,
  output logic [15:0]         ebi_data_out,
  output logic                ebi_data_oe,
  input  logic                ebi_wr,
  input  logic                ebi_rd,
  input  logic                ebi_cs,
  output logic [NUM_PINS-1:0] pin_cfg_valid,
  output logic [1:0]          pin_cfg_type,
  output logic [31:0]         pin_cfg_data,
  input  logic [NUM_PINS-1:0] pin_cfg_ready,
  output logic                irq_overflow
);
  localparam int CMD_W = cmd_width(PIN_W);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  typedef struct packed {
    logic [PIN_W-1:0] pin;
    logic [1:0]       typ;
    logic [31:0]      start;
    logic [31:0]      data;
  } cmd_t;

  // ---------------- EBI decode ----------------
  logic [20:0] addr_off;
  logic [3:0]  off;
  logic        in_range;
  logic        wr_q, rd_q, wr_ev, rd_ev;
  logic        ctrl_wr, timer_clr, flush, commit;

  assign addr_off  = ebi_addr - BASE_ADDR;
  assign in_range  = (ebi_addr >= BASE_ADDR) && (addr_off <= 21'(REG_LAST));
  assign off       = addr_off[3:0];
  assign wr_ev     = ebi_cs & ebi_wr & ~wr_q & in_range;
  assign rd_ev     = ebi_cs & ebi_rd & ~rd_q & in_range;
  assign ctrl_wr   = wr_ev && (off == REG_CTRL);
  assign timer_clr = ctrl_wr & ebi_data_in[CTRL_CLR_BIT];
  assign flush     = ctrl_wr & ebi_data_in[CTRL_FLUSH_BIT];
  assign commit    = wr_ev && (off == REG_COMMIT);

  // Strobe history so a held strobe produces a single access
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_q <= 1'b0;
      rd_q <= 1'b0;
    end else begin
      wr_q <= ebi_cs & ebi_wr;
      rd_q <= ebi_cs & ebi_rd;
    end
  end

  // ---------------- Host registers ----------------
  logic             run_q, ovf_q;
  logic [PIN_W-1:0] cmd_pin_q;
  logic [1:0]       cmd_type_q;
  logic [31:0]      start_q, data_q;

  // Staging registers; they survive a commit so the host can reuse fields
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run_q      <= 1'b0;
      cmd_pin_q  <= '0;
      cmd_type_q <= '0;
      start_q    <= '0;
      data_q     <= '0;
    end else if (wr_ev) begin
      case (off)
        REG_CTRL:     run_q          <= ebi_data_in[CTRL_RUN_BIT];
        REG_CMD_PIN:  cmd_pin_q      <= ebi_data_in[PIN_W-1:0];
        REG_CMD_TYPE: cmd_type_q     <= ebi_data_in[1:0];
        REG_START_LO: start_q[15:0]  <= ebi_data_in;
        REG_START_HI: start_q[31:16] <= ebi_data_in;
        REG_DATA_LO:  data_q[15:0]   <= ebi_data_in;
        REG_DATA_HI:  data_q[31:16]  <= ebi_data_in;
        default: ;
      endcase
    end
  end

  // ---------------- Timer ----------------
  logic [31:0] timer_q;

  // Free-running while run is set; clear beats increment
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         timer_q <= '0;
    else if (timer_clr) timer_q <= '0;
    else if (run_q)     timer_q <= timer_q + 32'd1;
  end

  // ---------------- FIFO ----------------
  cmd_t             push_cmd;
  logic [CMD_W-1:0] head_cmd;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_full, fifo_empty, fifo_pop;

  assign push_cmd = '{pin: cmd_pin_q, typ: cmd_type_q, start: start_q, data: data_q};

  cmd_fifo #(
    .W     (CMD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (reset),
    .push      (commit),
    .push_data (push_cmd),
    .pop       (fifo_pop),
    .pop_data  (head_cmd),
    .flush     (flush),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Sticky overflow on a dropped commit; host clears by writing STATUS bit10
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      ovf_q <= 1'b0;
    else if (commit && fifo_full && !flush)
      ovf_q <= 1'b1;
    else if (wr_ev && (off == REG_STATUS) && ebi_data_in[STAT_OVF_BIT])
      ovf_q <= 1'b0;
  end

  assign irq_overflow = ovf_q;

  // ---------------- Scheduler ----------------
  sched_state_e state_q, state_d;
  cmd_t         stg_q;

  // Scheduler state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Head-of-line command, captured when the scheduler pops the FIFO
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        stg_q <= '0;
    else if (fifo_pop) stg_q <= head_cmd;
  end

  // Next state, FIFO pop and one-hot valid; an issued command is never
  // abandoned, only a pending one can be flushed
  always_comb begin
    state_d       = state_q;
    fifo_pop      = 1'b0;
    pin_cfg_valid = '0;
    case (state_q)
      ST_IDLE: begin
        if (run_q && !fifo_empty && !flush) begin
          fifo_pop = 1'b1;
          state_d  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (flush)                              state_d = ST_IDLE;
        else if (run_q && timer_q >= stg_q.start) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        pin_cfg_valid[stg_q.pin] = 1'b1;
        if (pin_cfg_ready[stg_q.pin]) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign pin_cfg_type = stg_q.typ;
  assign pin_cfg_data = stg_q.data;

  // ---------------- Read path ----------------
  logic [15:0] status_w, rd_mux, time_hi_snap;

  // STATUS word assembly
  always_comb begin
    status_w                 = '0;
    status_w[5:0]            = 6'(fifo_count);
    status_w[STAT_EMPTY_BIT] = fifo_empty;
    status_w[STAT_FULL_BIT]  = fifo_full;
    status_w[STAT_OVF_BIT]   = ovf_q;
    status_w[13:12]          = state_q;
  end

  // Readback multiplexer
  always_comb begin
    rd_mux = '0;
    case (off)
      REG_CTRL:     rd_mux[CTRL_RUN_BIT] = run_q;
      REG_STATUS:   rd_mux = status_w;
      REG_CMD_PIN:  rd_mux = 16'(cmd_pin_q);
      REG_CMD_TYPE: rd_mux = 16'(cmd_type_q);
      REG_START_LO: rd_mux = start_q[15:0];
      REG_START_HI: rd_mux = start_q[31:16];
      REG_DATA_LO:  rd_mux = data_q[15:0];
      REG_DATA_HI:  rd_mux = data_q[31:16];
      REG_TIME_LO:  rd_mux = timer_q[15:0];
      REG_TIME_HI:  rd_mux = time_hi_snap;
      default:      rd_mux = '0;
    endcase
  end

  // Registered read data; TIME_LO also freezes the upper half so the
  // following TIME_HI read forms a coherent 32-bit value
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ebi_data_out <= '0;
      time_hi_snap <= '0;
    end else if (rd_ev) begin
      ebi_data_out <= rd_mux;
      if (off == REG_TIME_LO) time_hi_snap <= timer_q[31:16];
    end
  end

  // Drive enable rises with the read data and drops once the strobe ends
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                 ebi_data_oe <= 1'b0;
    else if (rd_ev)             ebi_data_oe <= 1'b1;
    else if (!(ebi_cs && ebi_rd)) ebi_data_oe <= 1'b0;
  end

endmodule

// File: doc/pin_cmd_scheduler.md
Name: pin_cmd_scheduler

Overview:
- EBI-mapped command scheduler for the per-pin PWM/sample generators in mecobo.
- Host writes timestamped configuration commands over the EBI bus; they are buffered in an in-order FIFO.
- Each command is released to the target pin's generator over a valid/ready handshake once a free-running global timer reaches the command's start time.
- Sits between the EBI decode in mecobo and the array of pin channels.

Parameters:
NUM_PINS, 8, number of pin channels addressed (power of 2, 2..64)
FIFO_DEPTH, 16, command FIFO entries (power of 2)
BASE_ADDR, 21'h000100, EBI word address of register 0
PIN_W, $clog2(NUM_PINS), pin index width

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
ebi_addr  in  21  EBI word address
ebi_data_in  in  16  EBI write data
ebi_data_out  out  16  EBI read data (registered)
ebi_data_oe  out  1  read-data drive enable for top-level tristate
ebi_wr  in  1  write strobe, active high
ebi_rd  in  1  read strobe, active high
ebi_cs  in  1  chip select, active high
pin_cfg_valid  out  NUM_PINS  one-hot command valid per pin
pin_cfg_type  out  2  command type (shared by all pins)
pin_cfg_data  out  32  command payload (shared by all pins)
pin_cfg_ready  in  NUM_PINS  per-pin accept
irq_overflow  out  1  level, equals sticky overflow flag

Behaviour:
- Reset (reset=0, async) clears all state. Outputs: ebi_data_out=0, ebi_data_oe=0, pin_cfg_valid=0, pin_cfg_type=0, pin_cfg_data=0, irq_overflow=0. Also clears timer=0, FIFO empty, run=0, FSM=IDLE.
- EBI access:
  - Write event: exactly one clk cycle where (ebi_cs&ebi_wr) is 1 and was 0 the previous cycle, with ebi_addr in [BASE_ADDR, BASE_ADDR+10]. Addresses outside this range are ignored.
  - Read event: same rule with ebi_rd.
  - Read data is registered and appears the cycle after the read event. It is held while cs&rd remain high.
  - ebi_data_oe is high from that cycle until cs&rd falls (registered deassert).
- Register map (offset):
  - 0 CTRL rw: bit0 run; bit1 timer_clr (write-only, self-clearing); bit2 flush (write-only, self-clearing).
  - 1 STATUS: [5:0] count, bit8 empty, bit9 full, bit10 overflow, [13:12] FSM state. Writing 1 to bit10 clears overflow.
  - 2 CMD_PIN: [PIN_W-1:0].
  - 3 CMD_TYPE: [1:0]; 0 NOP, 1 SET_PERIOD, 2 SET_DUTY, 3 SET_ENABLE.
  - 4/5 START_LO/HI.
  - 6/7 DATA_LO/HI.
  - 8 COMMIT: any write pushes {pin,type,start,data} from registers 2-7. Registers 2-7 keep their values after commit.
  - 9 TIME_LO: read returns timer[15:0] and snapshots timer[31:16].
  - 10 TIME_HI: returns the snapshot.
- Timer: 32 bit, +1 per cycle while run=1, wraps 0xFFFFFFFF->0. timer_clr has priority over increment.
- FIFO:
  - Push when full: command dropped, overflow set (sticky).
  - Simultaneous push and pop: count unchanged.
  - Flush empties the FIFO in one cycle. If it coincides with a COMMIT the push is also discarded.
- Scheduler FSM:
  - IDLE: if run && !empty, pop head into staging register -> WAIT.
  - WAIT: if timer >= start (unsigned, no wrap compensation; past start issues immediately) -> ISSUE. Flush -> IDLE, discards staging. run=0 holds WAIT, timer frozen.
  - ISSUE: pin_cfg_valid[pin]=1; type and data driven from staging; all held stable until pin_cfg_ready[pin]=1 in the same cycle -> IDLE, valid drops the next cycle.
    - Flush, run=0 and overflow do not abort ISSUE.
    - NOP type still issues a handshake.
- Ordering is strict FIFO (head-of-line blocking).
- Minimum gap between consecutive issues is 2 cycles after a handshake (IDLE, WAIT).
- Latency: a command with start <= timer reaches ISSUE 3 cycles after the commit write event.
- pin_cfg_ready for non-selected pins is ignored.

Decomposition:
- Package pin_sched_pkg: register offsets, CMD_* type encodings, FSM state enum, command struct width constant (PIN_W+2+64).
- One sub-module: cmd_fifo (synchronous FIFO, parameterised width and depth, push/pop/flush, count/full/empty).

Test Plan:
- Reset mid-ISSUE (valid[3]=1): assert reset=0 asynchronously -> pin_cfg_valid=0 immediately, STATUS reads 0x0100 after release.
- run=1, commit pin=2 type=1 start=0x00000000 data=0x00001234 -> pin_cfg_valid=8'h04, data=0x1234, type=1 three cycles after commit; holds 5 cycles until ready[2] asserted, then 0.
- timer_clr+run, commit pin=5 start=100 -> valid[5] rises on the cycle timer reads >=100; TIME_LO read then TIME_HI returns consistent 32-bit value >=100.
- 17 commits with run=0 -> count=16, full=1, overflow=1, irq_overflow=1; write STATUS bit10=1 -> irq_overflow=0, count still 16.
- Two commits: start=50 pin0, then start=10 pin1 -> pin0 issued first at timer>=50, pin1 immediately after (2-cycle gap), ordering preserved.
- Command in WAIT with start=0xFFFF0000, write flush -> FSM IDLE, count=0, no valid ever asserted.
